gpio_bank: RTL and testbench



---
 rtl/gpio_bank_pkg.sv | 31 +++
 rtl/gpio_bank_sync.sv | 33 +++
 rtl/gpio_bank.sv | 159 +++++++++++++++
 tb/tb_gpio_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared definitions for gpio_bank: register offsets, register select codes
// and the arm-counter width helper.
package gpio_bank_pkg;

  localparam logic [7:0] OFS_OUT     = 8'h00;
  localparam logic [7:0] OFS_DIR     = 8'h04;
  localparam logic [7:0] OFS_IN      = 8'h08;
  localparam logic [7:0] OFS_OUT_SET = 8'h0C;
  localparam logic [7:0] OFS_OUT_CLR = 8'h10;
  localparam logic [7:0] OFS_RISE_EN = 8'h14;
  localparam logic [7:0] OFS_FALL_EN = 8'h18;
  localparam logic [7:0] OFS_STATUS  = 8'h1C;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_OUT,
    SEL_DIR,
    SEL_IN,
    SEL_OUT_SET,
    SEL_OUT_CLR,
    SEL_RISE_EN,
    SEL_FALL_EN,
    SEL_STATUS
  } reg_sel_e;

  // The counter must be able to hold the value stages+1.
  function automatic int arm_cnt_w(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/gpio_bank_sync.sv
// Multi-flop input synchroniser with a trailing "prev" flop; exposes the
// synchronised vector and single-cycle rise/fall indications.
module gpio_bank_sync #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain_q [STAGES];
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[STAGES-1];
    end
  end

  assign sync = chain_q[STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank behind the local write/strobe bus with a 1-cycle registered read:
// per-pin direction, atomic set/clear, synchronised inputs, edge interrupts.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          STRB_W      = DATA_W / 8,
  parameter int          N_GPIO      = 16,
  parameter int unsigned BASE_ADDR   = 32'h20,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic              irq,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic [STRB_W-1:0] wstrb,
  output logic              wready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int ARM_W = arm_cnt_w(SYNC_STAGES);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  // Handshake: writes are always accepted (wready=1) at the edge sampling wen;
  // ren at edge N yields rdata/rvalid for exactly the cycle after edge N.

  function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - ADDR_W'(BASE_ADDR);
    decode = SEL_NONE;
    if (off == ADDR_W'(OFS_OUT))     decode = SEL_OUT;
    if (off == ADDR_W'(OFS_DIR))     decode = SEL_DIR;
    if (off == ADDR_W'(OFS_IN))      decode = SEL_IN;
    if (off == ADDR_W'(OFS_OUT_SET)) decode = SEL_OUT_SET;
    if (off == ADDR_W'(OFS_OUT_CLR)) decode = SEL_OUT_CLR;
    if (off == ADDR_W'(OFS_RISE_EN)) decode = SEL_RISE_EN;
    if (off == ADDR_W'(OFS_FALL_EN)) decode = SEL_FALL_EN;
    if (off == ADDR_W'(OFS_STATUS))  decode = SEL_STATUS;
  endfunction

  reg_sel_e          wsel;
  reg_sel_e          rsel;
  logic [DATA_W-1:0] bmask;
  logic [DATA_W-1:0] wbits;
  logic [N_GPIO-1:0] m;
  logic [N_GPIO-1:0] wb;
  logic              unused_hi;

  logic [N_GPIO-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;
  logic [ARM_W-1:0]  arm_cnt_q;
  logic              armed;
  logic [N_GPIO-1:0] pin_sync, pin_rise, pin_fall;
  logic [N_GPIO-1:0] set_ev, w1c;
  logic [DATA_W-1:0] rd_next;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  assign wsel = decode(waddr);
  assign rsel = decode(raddr);

  always_comb begin
    bmask = '0;
    for (int i = 0; i < DATA_W; i++) bmask[i] = wstrb[i/8];
  end

  assign wbits     = wdata & bmask;
  assign m         = bmask[N_GPIO-1:0];
  assign wb        = wbits[N_GPIO-1:0];
  assign unused_hi = ^{wbits, bmask};

  gpio_bank_sync #(
    .W      (N_GPIO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_in),
    .sync  (pin_sync),
    .rise  (pin_rise),
    .fall  (pin_fall)
  );

  // Until the chain and prev flop hold real pin samples, reset zeros would
  // look like edges; the arm counter masks that window.
  assign armed = (arm_cnt_q == ARM_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arm_cnt_q <= '0;
    else if (!armed) arm_cnt_q <= arm_cnt_q + ARM_W'(1);
  end

  assign set_ev = armed ? ((pin_rise & rise_en_q) | (pin_fall & fall_en_q)) : '0;
  assign w1c    = (wen && wsel == SEL_STATUS) ? wb : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wen) begin
      case (wsel)
        SEL_OUT:     out_q     <= (out_q & ~m) | wb;
        SEL_OUT_SET: out_q     <= out_q | wb;
        SEL_OUT_CLR: out_q     <= out_q & ~wb;
        SEL_DIR:     dir_q     <= (dir_q & ~m) | wb;
        SEL_RISE_EN: rise_en_q <= (rise_en_q & ~m) | wb;
        SEL_FALL_EN: fall_en_q <= (fall_en_q & ~m) | wb;
        default: ;
      endcase
    end
  end

  // A new edge in the same cycle as its W1C keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= '0;
    else        status_q <= (status_q & ~w1c) | set_ev;
  end

  always_comb begin
    rd_next = '0;
    case (rsel)
      SEL_OUT:     rd_next[N_GPIO-1:0] = out_q;
      SEL_DIR:     rd_next[N_GPIO-1:0] = dir_q;
      SEL_IN:      rd_next[N_GPIO-1:0] = pin_sync;
      SEL_RISE_EN: rd_next[N_GPIO-1:0] = rise_en_q;
      SEL_FALL_EN: rd_next[N_GPIO-1:0] = fall_en_q;
      SEL_STATUS:  rd_next[N_GPIO-1:0] = status_q;
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= ren ? rd_next : '0;
      rvalid_q <= ren;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |status_q;
  assign wready   = 1'b1;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: a default 16-pin/2-stage instance and a
// 32-pin/3-stage instance sharing one clock.
module tb_gpio_bank;

  localparam logic [31:0] A_OUT    = 32'h20;
  localparam logic [31:0] A_DIR    = 32'h24;
  localparam logic [31:0] A_IN     = 32'h28;
  localparam logic [31:0] A_SET    = 32'h2C;
  localparam logic [31:0] A_CLR    = 32'h30;
  localparam logic [31:0] A_RISE   = 32'h34;
  localparam logic [31:0] A_FALL   = 32'h38;
  localparam logic [31:0] A_STATUS = 32'h3C;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst32_n = 1'b0;
  always #5 clk = ~clk;

  // 16-pin instance
  logic [15:0] gpio_in = 16'hFFFF;
  logic [15:0] gpio_out, gpio_oe;
  logic        irq, wready, rvalid;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0, rdata;
  logic        wen = 1'b0, ren = 1'b0;
  logic [3:0]  wstrb = '0;

  gpio_bank dut (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq), .waddr(waddr), .wdata(wdata), .wen(wen),
    .wstrb(wstrb), .wready(wready), .raddr(raddr), .ren(ren),
    .rdata(rdata), .rvalid(rvalid)
  );

  // 32-pin, 3-stage instance
  logic [31:0] gpio_in32 = '0;
  logic [31:0] gpio_out32, gpio_oe32;
  logic        irq32, wready32, rvalid32;
  logic [31:0] waddr32 = '0, wdata32 = '0, raddr32 = '0, rdata32;
  logic        wen32 = 1'b0, ren32 = 1'b0;
  logic [3:0]  wstrb32 = '0;

  gpio_bank #(.N_GPIO(32), .SYNC_STAGES(3)) dut32 (
    .clk(clk), .rst_n(rst32_n), .gpio_in(gpio_in32), .gpio_out(gpio_out32),
    .gpio_oe(gpio_oe32), .irq(irq32), .waddr(waddr32), .wdata(wdata32),
    .wen(wen32), .wstrb(wstrb32), .wready(wready32), .raddr(raddr32),
    .ren(ren32), .rdata(rdata32), .rvalid(rvalid32)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd_val;
  logic        rd_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    waddr = a; wdata = d; wstrb = s; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic vld);
    @(negedge clk);
    raddr = a; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    v = rdata; vld = rvalid;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    waddr32 = a; wdata32 = d; wstrb32 = 4'hF; wen32 = 1'b1;
    @(posedge clk); #1;
    wen32 = 1'b0;
  endtask

  initial begin
    // reset state with pins held high
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
    check("rst_gpio_oe", {16'h0, gpio_oe}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_wready", {31'h0, wready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1; rst32_n = 1'b1;

    // no spurious edge from arming
    repeat (6) @(posedge clk);
    wr(A_RISE, 32'hFFFF, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    check("arm_irq", {31'h0, irq}, 32'h0);
    rd(A_STATUS, rd_val, rd_vld);
    check("arm_status", rd_val, 32'h0);

    // OUT / SET / CLR
    wr(A_OUT, 32'h00A5, 4'hF);
    wr(A_SET, 32'h0100, 4'hF);
    wr(A_CLR, 32'h0001, 4'hF);
    check("out_setclr", {16'h0, gpio_out}, 32'h01A4);
    rd(A_OUT, rd_val, rd_vld);
    check("rd_out", rd_val, 32'h01A4);
    check("rd_out_vld", {31'h0, rd_vld}, 32'h1);
    @(posedge clk); #1;
    check("rd_vld_drop", {31'h0, rvalid}, 32'h0);
    check("rd_data_drop", rdata, 32'h0);
    rd(A_SET, rd_val, rd_vld);
    check("rd_set_zero", rd_val, 32'h0);

    // byte strobes on DIR
    wr(A_DIR, 32'hFFFF, 4'b0001);
    check("dir_strb", {16'h0, gpio_oe}, 32'h00FF);
    rd(A_DIR, rd_val, rd_vld);
    check("rd_dir", rd_val, 32'h00FF);
    rd(A_IN, rd_val, rd_vld);
    check("rd_in", rd_val, 32'hFFFF);

    // read and write of OUT in the same cycle returns the old value
    @(negedge clk);
    waddr = A_OUT; wdata = 32'h0005; wstrb = 4'hF; wen = 1'b1;
    raddr = A_OUT; ren = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
    check("rw_same_old", rdata, 32'h01A4);
    check("rw_same_new", {16'h0, gpio_out}, 32'h0005);

    // unmapped writes, including an address below the base
    wr(32'h40, 32'hFFFF, 4'hF);
    wr(32'h00, 32'hFFFF, 4'hF);
    check("unmapped_wr", {16'h0, gpio_out}, 32'h0005);

    // rising edge on pin 3
    wr(A_RISE, 32'h0008, 4'hF);
    @(negedge clk); gpio_in = 16'hFFF7;
    repeat (4) @(posedge clk);
    #1;
    check("fall_not_en", {31'h0, irq}, 32'h0);
    @(negedge clk); gpio_in = 16'hFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rise_e1_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("rise_e2_irq", {31'h0, irq}, 32'h1);
    rd(A_STATUS, rd_val, rd_vld);
    check("rise_status", rd_val, 32'h0008);
    wr(A_STATUS, 32'h0008, 4'hF);
    check("w1c_irq", {31'h0, irq}, 32'h0);

    // falling edge on pin 0 colliding with its W1C
    wr(A_FALL, 32'h0001, 4'hF);
    @(negedge clk); gpio_in = 16'hFFFE;
    repeat (3) @(posedge clk);
    #1;
    check("fall_irq", {31'h0, irq}, 32'h1);
    @(negedge clk); gpio_in = 16'hFFFF;
    repeat (4) @(posedge clk);
    wr(A_STATUS, 32'h0001, 4'b0010);
    check("w1c_strb_off", {31'h0, irq}, 32'h1);
    @(negedge clk); gpio_in = 16'hFFFE;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    waddr = A_STATUS; wdata = 32'h0001; wstrb = 4'hF; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    check("set_wins_irq", {31'h0, irq}, 32'h1);
    rd(A_STATUS, rd_val, rd_vld);
    check("set_wins_status", rd_val, 32'h0001);
    wr(A_STATUS, 32'h0001, 4'hF);
    check("w1c_clear", {31'h0, irq}, 32'h0);

    // 32-pin / 3-stage instance
    @(negedge clk);
    raddr32 = 32'h40; ren32 = 1'b1;
    @(posedge clk); #1;
    ren32 = 1'b0;
    check("u32_unmapped_data", rdata32, 32'h0);
    check("u32_unmapped_vld", {31'h0, rvalid32}, 32'h1);
    wr32(A_RISE, 32'hFFFF_FFFF);
    @(negedge clk);
    gpio_in32 = 32'hDEAD_BEEF;
    raddr32 = A_IN; ren32 = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      check("u32_in_old", rdata32, 32'h0);
      check("u32_in_vld", {31'h0, rvalid32}, 32'h1);
      check("u32_irq_early", {31'h0, irq32}, 32'h0);
    end
    @(posedge clk); #1;
    check("u32_in_new", rdata32, 32'hDEAD_BEEF);
    check("u32_irq", {31'h0, irq32}, 32'h1);

    // async reset in the middle of a read
    @(posedge clk); #3;
    rst32_n = 1'b0;
    #1;
    check("u32_rst_rvalid", {31'h0, rvalid32}, 32'h0);
    check("u32_rst_rdata", rdata32, 32'h0);
    check("u32_rst_irq", {31'h0, irq32}, 32'h0);
    @(negedge clk);
    ren32 = 1'b0;
    rst32_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
